pkt_fifo: RTL and testbench

Parametrised packet FIFO for the 4-port switch: the next-generation per-port ingress buffer. It adds selectable first-word-fall-through (FWFT) or registered read mode and a non-power-of-two depth. It also adds programmable almost-full/almost-empty flags, a head-of-queue target peek for the arbiter, write-through when full, and a saturating dropped-packet counter. One instance sits between each input port and the crossbar arbiter.

---
 rtl/switch_pkg.sv | 23 ++
 rtl/pkt_fifo_mem.sv | 25 ++
 rtl/pkt_fifo.sv | 139 +++++++++++++
 tb/tb_pkt_fifo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared packet layout for the 4-port switch.
// A packet is {source, target, data}, with source in the MSBs.
package switch_pkg;

  localparam int unsigned PKT_SIZE_DEF = 16;
  localparam int unsigned ADDR_W_DEF   = 4;

  // Field positions for the default packet layout
  localparam int unsigned SRC_MSB = PKT_SIZE_DEF - 1;
  localparam int unsigned TGT_MSB = SRC_MSB - ADDR_W_DEF;
  localparam int unsigned TGT_LSB = TGT_MSB - ADDR_W_DEF + 1;

  // Target field of a packet with any layout, for packets up to 64 bits wide.
  // The packet is passed zero-extended.
  function automatic logic [31:0] pkt_target(input logic [63:0]   pkt,
                                             input int unsigned   pkt_size,
                                             input int unsigned   addr_w);
    logic [63:0] sh;
    sh = pkt >> (pkt_size - 2 * addr_w);
    return 32'(sh & ((64'd1 << addr_w) - 64'd1));
  endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// Packet storage for pkt_fifo.
// One synchronous write port and one asynchronous read port. The array is not reset.
module pkt_fifo_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: stores the accepted packet
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/pkt_fifo.sv
// Per-port ingress packet FIFO.
// Selectable FWFT or registered read, any depth >= 2, programmable almost flags,
// head-of-queue target peek, write-through when full, and a saturating drop counter.
module pkt_fifo
  import switch_pkg::*;
#(
  parameter int unsigned PKT_SIZE = PKT_SIZE_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned DROP_W   = 8,
  localparam int unsigned PtrW    = $clog2(DEPTH),
  localparam int unsigned CntW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PKT_SIZE-1:0] data_in,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic                clr_drop,
  output logic [PKT_SIZE-1:0] data_out,
  output logic                data_valid,
  output logic [ADDR_W-1:0]   header_out,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [CntW-1:0]     fifo_count,
  output logic [DROP_W-1:0]   drop_count
);

  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                empty, full, rd_acc, wr_acc, drop_ev;
  logic [PKT_SIZE-1:0] head;

  // Explicit wrap so non-power-of-two depths work
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign rd_acc  = rd_en && !empty;
  // A read in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_acc  = wr_en && (!full || rd_acc);
  assign drop_ev = wr_en && !wr_acc;

  pkt_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_SIZE)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Next-state for pointers, occupancy and drop counter
  always_comb begin
    wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    drop_d = drop_q;
    if (clr_drop) begin
      drop_d = drop_ev ? DROP_W'(1) : '0;
    end else if (drop_ev && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Flags and peek decode from the registered occupancy
  always_comb begin
    fifo_count   = count_q;
    fifo_full    = full;
    fifo_empty   = empty;
    almost_full  = 32'(count_q) >= AF_LEVEL;
    almost_empty = 32'(count_q) <= AE_LEVEL;
    drop_count   = drop_q;
    header_out   = empty ? '0 : ADDR_W'(pkt_target(64'(head), PKT_SIZE, ADDR_W));
  end

  if (FWFT != 0) begin : g_fwft
    // Head is presented directly; a read just advances to the next entry
    always_comb begin
      data_out   = empty ? '0 : head;
      data_valid = !empty;
    end
  end else begin : g_reg
    logic [PKT_SIZE-1:0] data_q, data_d;
    logic                valid_q, valid_d;

    // Capture head on an accepted read; valid is a one-cycle pulse
    always_comb begin
      data_d  = rd_acc ? head : data_q;
      valid_d = rd_acc;
    end

    // Registered read data with synchronous reset
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
  end

endmodule

// File: tb/tb_pkt_fifo.sv
// Bench for pkt_fifo: a registered-read instance with default parameters and an
// FWFT instance with DEPTH=6 share one stimulus stream. A queue-based model of each
// is compared against every output after every clock edge.
module tb_pkt_fifo;

  localparam int unsigned D0 = 8;
  localparam int unsigned D1 = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0, clr_drop = 1'b0;
  logic [15:0] data_in = '0;

  always #5 clk = ~clk;

  logic [15:0] r_data, f_data;
  logic        r_valid, f_valid, r_full, f_full, r_empty, f_empty;
  logic        r_af, f_af, r_ae, f_ae;
  logic [3:0]  r_header, f_header, r_count;
  logic [2:0]  f_count;
  logic [7:0]  r_drop, f_drop;

  pkt_fifo u_r (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .clr_drop(clr_drop), .data_out(r_data), .data_valid(r_valid), .header_out(r_header),
    .fifo_full(r_full), .fifo_empty(r_empty), .almost_full(r_af), .almost_empty(r_ae),
    .fifo_count(r_count), .drop_count(r_drop)
  );

  pkt_fifo #(.DEPTH(D1), .FWFT(1)) u_f (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .clr_drop(clr_drop), .data_out(f_data), .data_valid(f_valid), .header_out(f_header),
    .fifo_full(f_full), .fifo_empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .fifo_count(f_count), .drop_count(f_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Models: stored packets in order, drop counters, registered read output
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          drop0 = 0, drop1 = 0;
  logic [15:0] dout0 = '0;
  logic        dv0 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_drop(input int d, input logic clr, input logic rej);
    if (clr) return rej ? 1 : 0;
    if (rej && d < 255) return d + 1;
    return d;
  endfunction

  task automatic model_step(input logic w, input logic r, input logic c, input logic [15:0] d);
    int          cnt;
    bit          ra, wa;
    logic [15:0] tmp;
    cnt = q0.size();
    ra  = r && cnt > 0;
    wa  = w && (cnt < D0 || ra);
    dv0 = ra;
    if (ra) dout0 = q0.pop_front();
    if (wa) q0.push_back(d);
    drop0 = next_drop(drop0, c, w && !wa);
    cnt = q1.size();
    ra  = r && cnt > 0;
    wa  = w && (cnt < D1 || ra);
    if (ra) tmp = q1.pop_front();
    if (wa) q1.push_back(d);
    drop1 = next_drop(drop1, c, w && !wa);
  endtask

  task automatic check_all();
    int          c0, c1;
    logic [3:0]  h0, h1;
    logic [15:0] fd;
    c0 = q0.size();
    c1 = q1.size();
    h0 = '0;
    h1 = '0;
    fd = '0;
    if (c0 > 0) h0 = q0[0][11:8];
    if (c1 > 0) begin
      h1 = q1[0][11:8];
      fd = q1[0];
    end
    chk("r_count",  32'(r_count),  32'(c0));
    chk("r_full",   32'(r_full),   32'(c0 == D0));
    chk("r_empty",  32'(r_empty),  32'(c0 == 0));
    chk("r_af",     32'(r_af),     32'(c0 >= D0 - 2));
    chk("r_ae",     32'(r_ae),     32'(c0 <= 1));
    chk("r_header", 32'(r_header), 32'(h0));
    chk("r_data",   32'(r_data),   32'(dout0));
    chk("r_valid",  32'(r_valid),  32'(dv0));
    chk("r_drop",   32'(r_drop),   32'(drop0));
    chk("f_count",  32'(f_count),  32'(c1));
    chk("f_full",   32'(f_full),   32'(c1 == D1));
    chk("f_empty",  32'(f_empty),  32'(c1 == 0));
    chk("f_af",     32'(f_af),     32'(c1 >= D1 - 2));
    chk("f_ae",     32'(f_ae),     32'(c1 <= 1));
    chk("f_header", 32'(f_header), 32'(h1));
    chk("f_data",   32'(f_data),   32'(fd));
    chk("f_valid",  32'(f_valid),  32'(c1 != 0));
    chk("f_drop",   32'(f_drop),   32'(drop1));
  endtask

  // One clock: drive on the falling edge, check 1 time unit after the rising edge
  task automatic step(input logic w, input logic r, input logic c, input logic [15:0] d);
    @(negedge clk);
    wr_en    = w;
    rd_en    = r;
    clr_drop = c;
    data_in  = d;
    model_step(w, r, c, d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset with write and read requests active; reset must dominate
  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    wr_en    = 1'b1;
    rd_en    = 1'b1;
    clr_drop = 1'b0;
    data_in  = 16'hDEAD;
    q0.delete();
    q1.delete();
    drop0 = 0;
    drop1 = 0;
    dout0 = '0;
    dv0   = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("lit_rst_empty", 32'(r_empty), 32'd1);
    chk("lit_rst_ae",    32'(f_ae),    32'd1);
    chk("lit_rst_data",  32'(r_data),  32'd0);

    // Three writes then three reads
    step(1, 0, 0, 16'h1A01);
    step(1, 0, 0, 16'h2B02);
    step(1, 0, 0, 16'h3C03);
    chk("lit_count3",  32'(r_count),  32'd3);
    chk("lit_header",  32'(r_header), 32'hA);
    step(0, 1, 0, 16'h0);
    chk("lit_rd1", 32'(r_data), 32'h1A01);
    chk("lit_dv1", 32'(r_valid), 32'd1);
    step(0, 1, 0, 16'h0);
    chk("lit_rd2", 32'(r_data), 32'h2B02);
    step(0, 1, 0, 16'h0);
    chk("lit_rd3", 32'(r_data), 32'h3C03);
    chk("lit_empty_after_rd", 32'(r_empty), 32'd1);
    step(0, 0, 0, 16'h0);
    chk("lit_dv_pulse_end", 32'(r_valid), 32'd0);

    // FWFT visibility before any read, then pop
    step(1, 0, 0, 16'h4D05);
    chk("lit_fwft_data",  32'(f_data),  32'h4D05);
    chk("lit_fwft_valid", 32'(f_valid), 32'd1);
    step(0, 1, 0, 16'h0);
    chk("lit_fwft_pop_data",  32'(f_data),  32'd0);
    chk("lit_fwft_pop_valid", 32'(f_valid), 32'd0);

    // Fill DEPTH=6 instance, then overflow, then write-through at full
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 16'h5000 + 16'(i) * 16'h0111);
      if (i == 2) chk("lit_af_at3", 32'(f_af), 32'd0);
      if (i == 3) chk("lit_af_at4", 32'(f_af), 32'd1);
    end
    chk("lit_full6", 32'(f_full), 32'd1);
    step(1, 0, 0, 16'hEEEE);
    chk("lit_drop1",  32'(f_drop),  32'd1);
    chk("lit_count6", 32'(f_count), 32'd6);
    chk("lit_head_kept", 32'(f_data), 32'h5000);
    step(1, 1, 0, 16'h7F07);
    chk("lit_wt_count", 32'(f_count), 32'd6);
    chk("lit_wt_drop",  32'(f_drop),  32'd1);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 16'h0);

    // Simultaneous write and read while empty: no bypass
    step(1, 1, 0, 16'h6E06);
    chk("lit_emp_wr_rd_valid", 32'(r_valid), 32'd0);
    chk("lit_emp_wr_rd_count", 32'(r_count), 32'd1);

    // Fill both, then clear coinciding with a rejected write
    for (int i = 0; i < 7; i++) step(1, 0, 0, 16'(32'h8100 + i));
    step(1, 0, 1, 16'h9999);
    chk("lit_clr_drop_r", 32'(r_drop), 32'd1);
    chk("lit_clr_drop_f", 32'(f_drop), 32'd1);
    for (int i = 0; i < 300; i++) step(1, 0, 0, 16'($urandom));
    chk("lit_sat_r", 32'(r_drop), 32'd255);
    chk("lit_sat_f", 32'(f_drop), 32'd255);
    step(0, 0, 1, 16'h0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 16'h0);

    // Streamed packets with interleaved reads across several pointer wraps
    for (int i = 0; i < 20; i++) step(1, (i % 3) != 0, 0, 16'(32'hA000 + i * 7));
    for (int i = 0; i < 10; i++) step(0, 1, 0, 16'h0);

    // Random traffic: fill-biased, then drain-biased
    for (int i = 0; i < 800; i++) begin
      int pw, pr;
      pw = (i < 400) ? 70 : 40;
      pr = (i < 400) ? 40 : 70;
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
           $urandom_range(0, 99) < 3, 16'($urandom));
    end

    // Reset while holding 4 entries and a nonzero drop count
    for (int i = 0; i < 8; i++) step(0, 1, 0, 16'h0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 16'(32'hC000 + i));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0);
    chk("lit_pre_rst_count", 32'(r_count), 32'd4);
    do_reset();
    chk("lit_rst_count", 32'(r_count), 32'd0);
    chk("lit_rst_empty2", 32'(r_empty), 32'd1);
    chk("lit_rst_valid", 32'(r_valid), 32'd0);
    chk("lit_rst_drop", 32'(f_drop), 32'd0);
    step(0, 1, 0, 16'h0);
    chk("lit_post_rst_rd_r", 32'(r_valid), 32'd0);
    chk("lit_post_rst_rd_f", 32'(f_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
